flash_burst_reader: RTL
=======================

FLASH_BURST_READER -- requirements
Module: flash_burst_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, read-data buffer depth in 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, number of cycles to wait for a flash ack before retrying (used only with FLASH_READER_TIMEOUT_EN).
REQ-003 SHALL have port i_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_start  in  1  one-cycle pulse that requests a burst.
REQ-006 SHALL have port i_start_address  in  32  burst byte address; bits [1:0] ignored.
REQ-007 SHALL have port i_length  in  16  burst length in 32-bit words; 0 means no-op.
REQ-008 SHALL have port o_busy  out  1  burst in progress.
REQ-009 SHALL have port o_done  out  1  one-cycle pulse when the burst completes.
REQ-010 SHALL have port o_timeout  out  1  one-cycle pulse on each ack timeout.
REQ-011 SHALL have ports o_data  out  32, o_valid  out  1, and i_ready  in  1, forming the consumer stream (first-word fall-through).
REQ-012 SHALL have ports o_flash_select  out  1, o_flash_read_rq  out  1, and o_flash_address  out  32, forming the request side to the flash controller.
REQ-013 SHALL have ports i_flash_ack  in  1 and i_flash_data  in  32, forming the response side from the flash controller.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, and FINISH.
REQ-015 IDLE: on i_start with i_length != 0, SHALL latch the address with bits [1:0] forced to 0, load remaining = i_length, and go to ISSUE; a start with i_length == 0 SHALL produce an o_done pulse on the next cycle with no flash access.
REQ-016 i_start SHALL be ignored in every state except IDLE.
REQ-017 ISSUE: when the FIFO has at least one free slot, SHALL assert o_flash_read_rq for exactly one cycle with o_flash_address = current address, then go to WAIT; otherwise it SHALL stay in ISSUE with rq low.
REQ-018 At most one flash read SHALL be outstanding at any time, and o_flash_read_rq SHALL never be high in two consecutive cycles.
REQ-019 o_flash_select SHALL be high in ISSUE and WAIT and low otherwise.
REQ-020 WAIT: on i_flash_ack, SHALL push i_flash_data into the FIFO, increment the address by 4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), decrement remaining, then go to FINISH if remaining reaches 0, else to ISSUE.
REQ-021 i_flash_ack SHALL be ignored outside WAIT; no FIFO push SHALL occur.
REQ-022 FINISH: when the FIFO is empty, SHALL pulse o_done for one cycle and go to IDLE.
REQ-023 o_busy SHALL be high in every state except IDLE.
REQ-024 FIFO: o_valid = not empty and o_data = head word; a pop SHALL occur when o_valid and i_ready are both high; a simultaneous push and pop SHALL leave the count unchanged; the FIFO SHALL never overflow.
REQ-025 Minimum latency: start accepted at cycle N SHALL give rq at N+1; an ack at cycle M SHALL give o_valid at M+1.

Reset
REQ-026 i_reset SHALL force, on the next edge, state IDLE, the FIFO empty, and o_busy, o_done, o_timeout, o_valid, o_flash_select, and o_flash_read_rq all 0, with o_flash_address and o_data 0.
REQ-027 Reset mid-burst SHALL abandon the burst with no o_done pulse; a late ack after reset SHALL be ignored per REQ-021.

Configuration
REQ-028 The optional feature SHALL be controlled by macro FLASH_READER_TIMEOUT_EN.
REQ-029 With FLASH_READER_TIMEOUT_EN defined, a WAIT cycle counter SHALL clear on entry to WAIT; if it reaches TIMEOUT_CYCLES with no ack, the block SHALL pulse o_timeout and return to ISSUE to re-request the same address, with remaining unchanged.
REQ-030 Without FLASH_READER_TIMEOUT_EN, o_timeout SHALL be tied to 0, no counter logic SHALL be present, and WAIT SHALL wait indefinitely.

Verification
REQ-031 Start with address 0x00001002 and length 3, ack 2 cycles after each rq, i_ready=1 -> addresses 0x1000, 0x1004, 0x1008; three words out in order; one o_done pulse.
REQ-032 Length 8 with i_ready=0 -> exactly 4 rqs (FIFO full) and no further rq; raising i_ready -> remaining 4 words fetched; o_done only after the last pop.
REQ-033 Start with address 0xFFFFFFFC and length 2 -> rq addresses 0xFFFFFFFC then 0x00000000.
REQ-034 i_start during a burst, stray ack in IDLE, and i_length=0 -> no effect, no effect, and o_done with zero rqs, respectively.
REQ-035 With FLASH_READER_TIMEOUT_EN and TIMEOUT_CYCLES=16, first ack withheld -> o_timeout pulse, same address re-requested, burst completes normally; reset asserted in WAIT -> all outputs 0 next cycle and no o_done.

Source files
------------

// File: rtl/flash_burst_reader.sv
// Burst reader: issues single-word flash reads into a small FWFT buffer for a stream consumer.
// Optional ack-timeout/retry enabled by defining FLASH_READER_TIMEOUT_EN.
`timescale 1ns/1ps
module flash_burst_reader #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_start_address,
    input  logic [15:0] i_length,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic [31:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_flash_select,
    output logic        o_flash_read_rq,
    output logic [31:0] o_flash_address,
    input  logic        i_flash_ack,
    input  logic [31:0] i_flash_data
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   remaining_q, remaining_d;
    logic          zl_done_q, zl_done_d;
    logic          done_fsm, timeout_fsm;
    logic          push, pop;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          fifo_empty, fifo_has_room;

`ifdef FLASH_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt_q;
    logic          wait_expired;

    // Counter sits at zero outside WAIT, so it is cleared on every entry.
    always_ff @(posedge i_clk) begin
        if (i_reset || state_q != WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
    assign wait_expired = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

    assign fifo_empty    = (count_q == '0);
    assign fifo_has_room = (count_q != CW'(FIFO_DEPTH));
    assign pop           = !fifo_empty && i_ready;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        zl_done_d       = 1'b0;
        o_busy          = 1'b1;
        o_flash_select  = 1'b0;
        o_flash_read_rq = 1'b0;
        done_fsm        = 1'b0;
        timeout_fsm     = 1'b0;
        push            = 1'b0;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    if (i_length != 16'd0) begin
                        addr_d      = {i_start_address[31:2], 2'b00};
                        remaining_d = i_length;
                        state_d     = ISSUE;
                    end else begin
                        zl_done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                o_flash_select = 1'b1;
                // Only request when the returning word is guaranteed a slot.
                if (fifo_has_room) begin
                    o_flash_read_rq = 1'b1;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                o_flash_select = 1'b1;
                if (i_flash_ack) begin
                    push        = 1'b1;
                    addr_d      = addr_q + 32'd4;
                    remaining_d = remaining_q - 16'd1;
                    state_d     = (remaining_q == 16'd1) ? FINISH : ISSUE;
                end
`ifdef FLASH_READER_TIMEOUT_EN
                else if (wait_expired) begin
                    timeout_fsm = 1'b1;
                    state_d     = ISSUE;
                end
`endif
            end
            FINISH: begin
                if (fifo_empty) begin
                    done_fsm = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            zl_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            zl_done_q   <= zl_done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_flash_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_valid         = !fifo_empty;
    assign o_data          = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign o_flash_address = addr_q;
    assign o_done          = done_fsm | zl_done_q;
    assign o_timeout       = timeout_fsm;
endmodule
